// File: rtl/atan2_arbiter_if.sv
// atan2_arbiter_if: request, atan2 issue/return and response bus of the atan2 arbiter.
interface atan2_arbiter_if #(
    parameter int N     = 4,
    parameter int WIDTH = 16
);
    logic [N-1:0]         req_valid;
    logic [N-1:0]         req_ready;
    logic [N*WIDTH-1:0]   req_y;
    logic [N*WIDTH-1:0]   req_x;
    logic [WIDTH-1:0]     atan_y;
    logic [WIDTH-1:0]     atan_x;
    logic [15:0]          atan_res;
    logic [N-1:0]         rsp_valid;
    logic [15:0]          rsp_data;
    logic [$clog2(N)-1:0] rsp_id;
    logic                 drain;
    logic                 drained;
    logic                 busy;

    modport master (
        output req_valid, req_y, req_x, atan_res, drain,
        input  req_ready, atan_y, atan_x, rsp_valid, rsp_data, rsp_id, drained, busy
    );
    modport slave (
        input  req_valid, req_y, req_x, atan_res, drain,
        output req_ready, atan_y, atan_x, rsp_valid, rsp_data, rsp_id, drained, busy
    );
endinterface

// File: rtl/atan2_arbiter.sv
// atan2_arbiter: round-robin sharing of one fixed-latency atan2 pipeline between N requesters.
// Define ATAN2_ARB_STATS_EN to add per-requester grant counters and a stall counter.
module atan2_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 16,
    parameter int DELAY = 8
) (
    input  logic            clk,
    input  logic            reset,
    atan2_arbiter_if.slave  bus
`ifdef ATAN2_ARB_STATS_EN
    ,
    output logic [N*32-1:0] stat_grants,
    output logic [31:0]     stat_stall
`endif
);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(DELAY + 3);
    localparam int TD = DELAY + 2;
    localparam logic [1:0] S_RUN = 2'd0, S_DRAIN = 2'd1, S_DRAINED = 2'd2;

    logic [1:0]    r_state;
    logic [IW-1:0] r_ptr;
    logic [CW-1:0] r_cnt;
    logic [TD-1:0] r_tag_v;
    logic [IW-1:0] r_tag_id [TD];
    logic [IW-1:0] w_idx;
    logic [IW-1:0] w_gnt_id;
    logic          w_gnt;
    logic          w_ret;
    logic [1:0]    w_state_nxt;

    // first valid requester after the pointer, wrapping modulo N
    always_comb begin
        w_gnt = 1'b0;
        w_gnt_id = '0;
        w_idx = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx = (int'(r_ptr) + k >= N) ? IW'(int'(r_ptr) + k - N) : IW'(int'(r_ptr) + k);
            if (!w_gnt && bus.req_valid[w_idx]) begin
                w_gnt = 1'b1;
                w_gnt_id = w_idx;
            end
        end
        w_gnt = w_gnt && r_state == S_RUN && !bus.drain && !reset;
    end

    assign w_ret = r_tag_v[TD-1];
    assign bus.req_ready = w_gnt ? N'(1) << w_gnt_id : '0;
    assign bus.busy = r_cnt != '0;
    assign bus.drained = r_state == S_DRAINED;
    assign w_state_nxt = (r_state == S_RUN) ? (bus.drain ? S_DRAIN : S_RUN) :
                         !bus.drain ? S_RUN :
                         (r_state == S_DRAINED || r_cnt == '0) ? S_DRAINED : S_DRAIN;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_RUN;
            r_ptr <= IW'(N - 1);
            r_cnt <= '0;
            r_tag_v <= '0;
            bus.atan_y <= '0;
            bus.atan_x <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_data <= '0;
            bus.rsp_id <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt <= r_cnt + CW'(w_gnt) - CW'(w_ret);
            r_tag_v <= {r_tag_v[TD-2:0], w_gnt};
            bus.rsp_valid <= w_ret ? N'(1) << r_tag_id[TD-1] : '0;
            if (w_gnt) begin
                r_ptr <= w_gnt_id;
                bus.atan_y <= bus.req_y[w_gnt_id*WIDTH +: WIDTH];
                bus.atan_x <= bus.req_x[w_gnt_id*WIDTH +: WIDTH];
            end
            if (w_ret) begin
                bus.rsp_data <= bus.atan_res;
                bus.rsp_id <= r_tag_id[TD-1];
            end
        end
    end

    // ids ride alongside the valid bits; one extra stage aligns them with the registered atan2 result
    always_ff @(posedge clk) begin
        r_tag_id[0] <= w_gnt_id;
        for (int i = 1; i < TD; i++) r_tag_id[i] <= r_tag_id[i-1];
    end

`ifdef ATAN2_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_grants <= '0;
            stat_stall <= '0;
        end else begin
            for (int i = 0; i < N; i++)
                if (w_gnt && w_gnt_id == IW'(i) && stat_grants[i*32 +: 32] != '1)
                    stat_grants[i*32 +: 32] <= stat_grants[i*32 +: 32] + 32'd1;
            if (|bus.req_valid && !w_gnt && stat_stall != '1)
                stat_stall <= stat_stall + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_atan2_arbiter.sv
// tb_atan2_arbiter: directed self-checking bench for atan2_arbiter with a delay-line atan2 stub.
module tb_atan2_arbiter;
    localparam int N = 4;
    localparam int W = 16;
    localparam int DELAY = 8;

    typedef struct {
        int          edge_n;
        int          id;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_rsp = 0;
    int   r0;
    exp_t exp_q[$];
    logic [15:0] atan_pipe [DELAY+1];
`ifdef ATAN2_ARB_STATS_EN
    logic [N*32-1:0] stat_grants;
    logic [31:0]     stat_stall;
    logic [31:0]     s0;
`endif

    atan2_arbiter_if #(.N(N), .WIDTH(W)) bus ();

    atan2_arbiter #(.N(N), .WIDTH(W), .DELAY(DELAY)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef ATAN2_ARB_STATS_EN
        ,
        .stat_grants(stat_grants),
        .stat_stall(stat_stall)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // atan2 stub: known angles for the directed pairs, otherwise a tag built from the operands
    function automatic logic [15:0] atan_ref(input logic [15:0] y, input logic [15:0] x);
        if (y == 16'd100 && x == 16'd100) return 16'h1922;
        if (y == 16'd0 && x == 16'hFFFB) return 16'h6488;
        return {y[7:0], x[7:0]};
    endfunction

    always @(posedge clk) begin
        atan_pipe[0] <= atan_ref(bus.atan_y, bus.atan_x);
        for (int i = 1; i <= DELAY; i++) atan_pipe[i] <= atan_pipe[i-1];
    end
    assign bus.atan_res = atan_pipe[DELAY];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sample();
        exp_t e;
        if (reset) begin
            exp_q.delete();
            return;
        end
        for (int i = 0; i < N; i++)
            if (bus.req_valid[i] && bus.req_ready[i])
                exp_q.push_back('{cyc + 1 + DELAY + 2, i, atan_ref(bus.req_y[i*W +: W], bus.req_x[i*W +: W])});
        if (|bus.rsp_valid) begin
            n_rsp++;
            if (exp_q.size() == 0) check("rsp_unexpected", 64'(bus.rsp_valid), 64'(0));
            else begin
                e = exp_q.pop_front();
                check("rsp_edge", 64'(cyc), 64'(e.edge_n));
                check("rsp_id", 64'(bus.rsp_id), 64'(e.id));
                check("rsp_onehot", 64'(bus.rsp_valid), 64'(1 << e.id));
                check("rsp_data", 64'(bus.rsp_data), 64'(e.data));
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        bus.req_valid = '0;
        bus.req_y = '0;
        bus.req_x = '0;
        bus.drain = 1'b0;
        repeat (3) step();
        bus.req_valid = 4'hF;
        #1;
        check("rst_ready", 64'(bus.req_ready), 64'(0));
        check("rst_atan_y", 64'(bus.atan_y), 64'(0));
        check("rst_atan_x", 64'(bus.atan_x), 64'(0));
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        check("rst_rsp_data", 64'(bus.rsp_data), 64'(0));
        check("rst_rsp_id", 64'(bus.rsp_id), 64'(0));
        check("rst_drained", 64'(bus.drained), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        bus.req_valid = '0;
        reset = 1'b0;
        step();

        // single op: requester 2, atan2(100,100) = pi/4
        bus.req_y[2*W +: W] = 16'd100;
        bus.req_x[2*W +: W] = 16'd100;
        bus.req_valid = 4'b0100;
        #1;
        check("op_ready", 64'(bus.req_ready), 64'(4'b0100));
        step();
        bus.req_valid = '0;
        check("op_atan_y", 64'(bus.atan_y), 64'(100));
        check("op_atan_x", 64'(bus.atan_x), 64'(100));
        check("op_busy", 64'(bus.busy), 64'(1));
        repeat (DELAY + 1) step();
        check("op_early", 64'(bus.rsp_valid), 64'(0));
        check("op_busy_late", 64'(bus.busy), 64'(1));
        step();
        check("op_rsp_valid", 64'(bus.rsp_valid), 64'(4'b0100));
        check("op_rsp_id", 64'(bus.rsp_id), 64'(2));
        check("op_rsp_data", 64'(bus.rsp_data), 64'(16'h1922));
        check("op_busy_done", 64'(bus.busy), 64'(0));
        step();
        check("op_pulse", 64'(bus.rsp_valid), 64'(0));
        check("op_hold", 64'(bus.rsp_data), 64'(16'h1922));

        // fairness from a fresh reset: order 0,1,2,3,0,1,2,3
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            bus.req_y[i*W +: W] = 16'(16 + i);
            bus.req_x[i*W +: W] = 16'(i);
        end
        r0 = n_rsp;
        bus.req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("fair_gnt", 64'(bus.req_ready), 64'(1 << (k % 4)));
            step();
        end
        bus.req_valid = '0;
`ifdef ATAN2_ARB_STATS_EN
        for (int i = 0; i < N; i++) check("stat_grants", 64'(stat_grants[i*32 +: 32]), 64'(2));
        check("stat_stall_fair", 64'(stat_stall), 64'(0));
`endif
        repeat (DELAY + 3) step();
        check("fair_rsp_count", 64'(n_rsp - r0), 64'(8));

        // back-to-back: requester 0 alone for 20 cycles, atan2(0,-5) = pi
        bus.req_y[0 +: W] = 16'd0;
        bus.req_x[0 +: W] = 16'hFFFB;
        r0 = n_rsp;
        bus.req_valid = 4'b0001;
        for (int k = 0; k < 20; k++) begin
            #1;
            check("b2b_gnt", 64'(bus.req_ready), 64'(1));
            if (k == 12 || k == 19) check("b2b_inflight", 64'(dut.r_cnt), 64'(DELAY + 2));
            step();
        end
        bus.req_valid = '0;
        repeat (DELAY + 3) step();
        check("b2b_rsp_count", 64'(n_rsp - r0), 64'(20));
        check("b2b_idle", 64'(bus.busy), 64'(0));

        // drain with six ops in flight
        bus.req_y[1*W +: W] = 16'h0021;
        bus.req_x[1*W +: W] = 16'h0001;
        bus.req_valid = 4'b0010;
        repeat (6) step();
        bus.drain = 1'b1;
        #1;
        check("drain_ready", 64'(bus.req_ready), 64'(0));
        bus.req_valid = '0;
        repeat (DELAY + 1) step();
        check("drain_wait", 64'(bus.drained), 64'(0));
        check("drain_busy", 64'(bus.busy), 64'(1));
        step();
        check("drain_last_rsp", 64'(bus.rsp_valid), 64'(4'b0010));
        check("drain_not_yet", 64'(bus.drained), 64'(0));
        step();
        check("drained", 64'(bus.drained), 64'(1));
`ifdef ATAN2_ARB_STATS_EN
        s0 = stat_stall;
`endif
        bus.req_valid = 4'b0100;
        #1;
        check("drained_ready", 64'(bus.req_ready), 64'(0));
        repeat (4) step();
        bus.req_valid = '0;
`ifdef ATAN2_ARB_STATS_EN
        check("stat_stall_drain", 64'(stat_stall - s0), 64'(4));
`endif
        bus.drain = 1'b0;
        bus.req_valid = 4'b0100;
        #1;
        check("resume_wait", 64'(bus.req_ready), 64'(0));
        step();
        check("resume_gnt", 64'(bus.req_ready), 64'(4'b0100));
        check("resume_drained", 64'(bus.drained), 64'(0));
        step();
        bus.req_valid = '0;
        repeat (DELAY + 3) step();

        // reset with five ops in flight drops them all
        bus.req_valid = 4'b1000;
        repeat (5) step();
        bus.req_valid = '0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid_busy", 64'(bus.busy), 64'(0));
        r0 = n_rsp;
        repeat (15) step();
        check("rst_mid_no_rsp", 64'(n_rsp - r0), 64'(0));
        check("sb_empty", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
